// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Byte-addressed data memory behind a valid/ready request/response
//            handshake. Supports byte/half/word loads and stores, load sign or
//            zero extension, a programmable number of wait states and an
//            error response for illegal access types.
// Options  : DMEM_ALIGN_CHK_EN - when defined, misaligned half/word accesses
//            are rejected with an error; otherwise they are aligned down.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DW          = 32,
  parameter int AW          = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [DW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic [1:0]    req_type_i,
  input  logic          req_sign_i,
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic [DW-1:0] resp_rdata_o,
  output logic          resp_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [1:0]      type_q, type_d;
  logic            sign_q, sign_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  // Storage is deliberately left out of reset.
  logic [7:0]      mem_q [2**AW];

  // Effective access: live request inputs while idle (zero-wait commit),
  // holding registers once the request has been accepted.
  logic            acc_we;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_wdata;
  logic [1:0]      acc_type;
  logic            acc_sign;
  logic            acc_err;
  logic [AW-1:0]   base_addr;
  logic [3:0]      lane_en;
  logic [3:0]      lane_we;
  logic [AW-1:0]   lane_addr [4];
  logic [7:0]      lane_rd   [4];
  logic [7:0]      lane_wd   [4];
  logic [DW-1:0]   load_val;
  logic            commit;

  // Address bits above the storage size are intentionally ignored.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[DW-1:AW];

  // Select the access source: inputs in IDLE, holding registers otherwise.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_type  = type_q;
    acc_sign  = sign_q;
    if (state_q == IDLE) begin
      acc_we    = req_we_i;
      acc_addr  = req_addr_i[AW-1:0];
      acc_wdata = req_wdata_i;
      acc_type  = req_type_i;
      acc_sign  = req_sign_i;
    end
  end

  // Decode size, aligned base address, error and per-byte lane addresses.
  always_comb begin
    lane_en   = 4'b0001;
    base_addr = acc_addr;
    case (acc_type)
      2'b01: begin
        lane_en   = 4'b0011;
        base_addr = {acc_addr[AW-1:1], 1'b0};
      end
      2'b10: begin
        lane_en   = 4'b1111;
        base_addr = {acc_addr[AW-1:2], 2'b00};
      end
      default: ;
    endcase
    acc_err = (acc_type == 2'b11);
`ifdef DMEM_ALIGN_CHK_EN
    acc_err = acc_err
            | ((acc_type == 2'b01) && acc_addr[0])
            | ((acc_type == 2'b10) && (acc_addr[1:0] != 2'b00));
`endif
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = base_addr + AW'(i);
      lane_rd[i]   = mem_q[lane_addr[i]];
      lane_wd[i]   = acc_wdata[8*i +: 8];
    end
  end

  // Assemble little-endian load data and extend it to the full width.
  always_comb begin
    load_val = '0;
    case (acc_type)
      2'b00: begin
        load_val      = {DW{acc_sign & lane_rd[0][7]}};
        load_val[7:0] = lane_rd[0];
      end
      2'b01: begin
        load_val       = {DW{acc_sign & lane_rd[1][7]}};
        load_val[15:0] = {lane_rd[1], lane_rd[0]};
      end
      default: begin
        load_val[31:0] = {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};
      end
    endcase
  end

  // Next-state, holding-register capture and response registration.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    type_d  = type_q;
    sign_d  = sign_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i[AW-1:0];
          wdata_d = req_wdata_i;
          type_d  = req_type_i;
          sign_d  = req_sign_i;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? '0 : load_val;
    end
  end

  // Store lanes fire only on the edge entering RESP, never while in reset.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_we[i] = commit & acc_we & ~acc_err & lane_en[i] & rst;
    end
  end

  // Control and response registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= 2'b00;
      sign_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      type_q  <= type_d;
      sign_q  <= sign_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Byte-lane writes into storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem_q[lane_addr[i]] <= lane_wd[i];
      end
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder: directed scenarios
//            plus randomized loads/stores against a byte-array reference.
//            Honors DMEM_ALIGN_CHK_EN for expected misalignment behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int WC    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [DW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [1:0]    req_type_i;
  logic          req_sign_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [DW-1:0] resp_rdata_o;
  logic          resp_err_o;

  int            n_checks;
  int            n_errors;
  logic [7:0]    mem_m [DEPTH];

  data_mem_responder #(
    .DW          (DW),
    .AW          (AW),
    .WAIT_CYCLES (WC)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_type_i   (req_type_i),
    .req_sign_i   (req_sign_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: memory as a byte array, access size 1<<type, little-endian.
  task automatic model_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [1:0] ty,
                              input logic sg, output logic [31:0] rd,
                              output logic er);
    int unsigned size;
    int unsigned a;
    logic [31:0] v;
    rd = 32'h0;
    er = 1'b0;
    if (ty == 2'b11) begin
      er = 1'b1;
      return;
    end
    size = 1 << ty;
    a    = addr % DEPTH;
    if ((a % size) != 0) begin
`ifdef DMEM_ALIGN_CHK_EN
      er = 1'b1;
      return;
`else
      a = a - (a % size);
`endif
    end
    if (we) begin
      for (int k = 0; k < int'(size); k++) begin
        mem_m[(a + k) % DEPTH] = 8'(wd >> (8 * k));
      end
      return;
    end
    v = 32'h0;
    for (int k = 0; k < int'(size); k++) begin
      v = v | (32'(mem_m[(a + k) % DEPTH]) << (8 * k));
    end
    if (sg && size < 4 && v[8*size-1]) begin
      v = v | (32'hFFFF_FFFF << (8 * size));
    end
    rd = v;
  endtask

  // One request/response transaction, with junk requests driven while busy
  // and resp_ready held low for 'hold' cycles once the response is up.
  task automatic do_txn(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] ty,
                        input logic sg, input int hold,
                        output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] snap_rd;
    logic        snap_err;
    int          cyc;
    model_access(we, addr, wd, ty, sg, exp_rd, exp_err);
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_type_i  = ty;
    req_sign_i  = sg;
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = $urandom & 32'hFFFF_F0FF;
    req_wdata_i = $urandom;
    req_type_i  = 2'b10;
    req_sign_i  = 1'($urandom_range(0, 1));
    cyc = 1;
    while (!resp_valid_o && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", cyc, WC + 1);
    snap_rd  = resp_rdata_o;
    snap_err = resp_err_o;
    check("rdata", resp_rdata_o, exp_rd);
    check("err", {31'b0, resp_err_o}, {31'b0, exp_err});
    resp_ready_i = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {31'b0, resp_valid_o}, 32'd1);
      check("hold_rdata", resp_rdata_o, snap_rd);
      check("hold_err", {31'b0, resp_err_o}, {31'b0, snap_err});
      check("hold_req_ready", {31'b0, req_ready_o}, 32'd0);
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_i = 1'b0;
    check("done_valid", {31'b0, resp_valid_o}, 32'd0);
    check("done_idle", {31'b0, req_ready_o}, 32'd1);
    rd = snap_rd;
    er = snap_err;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b0;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    req_type_i   = 2'b00;
    req_sign_i   = 1'b0;
    resp_ready_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready_o}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    check("rst_rdata", resp_rdata_o, 32'h0);
    check("rst_err", {31'b0, resp_err_o}, 32'd0);
    rst = 1'b1;

    // Give the low 256 bytes known contents.
    for (int a = 0; a < 256; a += 4) begin
      do_txn(1'b1, 32'(a), $urandom, 2'b10, 1'b0, 0, rd, er);
    end

    // Word store/load round trip
    do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, rd, er);
    check("st_word_rdata", rd, 32'h0);
    do_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
    check("ld_word", rd, 32'hDEAD_BEEF);
    check("ld_word_err", {31'b0, er}, 32'd0);

    // Byte store, signed/unsigned byte loads, word reload
    do_txn(1'b1, 32'h13, 32'h80, 2'b00, 1'b0, 0, rd, er);
    do_txn(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, rd, er);
    check("ld_byte_s", rd, 32'hFFFF_FF80);
    do_txn(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, rd, er);
    check("ld_byte_u", rd, 32'h0000_0080);
    do_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
    check("ld_word_merge", rd, 32'h80AD_BEEF);

    // Misaligned half load
    do_txn(1'b0, 32'h11, 32'h0, 2'b01, 1'b0, 0, rd, er);
`ifdef DMEM_ALIGN_CHK_EN
    check("mis_half_err", {31'b0, er}, 32'd1);
    check("mis_half_rdata", rd, 32'h0);
`else
    check("mis_half_err", {31'b0, er}, 32'd0);
    check("mis_half_rdata", rd, 32'h0000_BEEF);
`endif

    // Back-pressure for 5 cycles
    do_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, rd, er);
    check("bp_rdata", rd, 32'h80AD_BEEF);

    // Illegal type store must not write
    do_txn(1'b1, 32'h10, 32'h1111_1111, 2'b11, 1'b0, 1, rd, er);
    check("illegal_err", {31'b0, er}, 32'd1);
    do_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
    check("illegal_nowrite", rd, 32'h80AD_BEEF);

    // Reset during WAIT of a store drops the store
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 32'h20;
    req_wdata_i = 32'h1234_5678;
    req_type_i  = 2'b10;
    req_sign_i  = 1'b0;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'b0, req_ready_o}, 32'd1);
    check("mid_rst_valid", {31'b0, resp_valid_o}, 32'd0);
    check("mid_rst_rdata", resp_rdata_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, rd, er);

    // Address wrap
    do_txn(1'b1, 32'(DEPTH + 4), 32'hA5A5_A5A5, 2'b10, 1'b0, 0, rd, er);
    do_txn(1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 0, rd, er);
    check("wrap_load", rd, 32'hA5A5_A5A5);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_F0FF, $urandom,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
